multi_clock_divider: RTL and testbench

- Parametrised successor to the single fixed-divisor clock divider.
- Provides CHANNELS independent divided clocks from one input_clock. Each channel has a run-time programmable divisor held in a shadow register and applied glitch-free at the channel's next toggle boundary.
- Each channel also produces a one-cycle tick strobe.
- Adds a global halt, a global phase-align sync, and per-channel disable (divisor 0).
- Feeds the processor core and peripheral timing logic in place of fixed per-rate divider instances.

---
 rtl/multi_clock_divider_pkg.sv | 13 +
 rtl/multi_clock_divider_channel.sv | 88 ++++++++
 rtl/multi_clock_divider.sv | 44 ++++
 tb/tb_multi_clock_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package multi_clock_divider_pkg;

  localparam int unsigned DefaultWidth     = 28;
  localparam int unsigned DefaultChannels  = 4;
  localparam int unsigned DIVISOR_DISABLED = 0;

  // Channel-select width; a single channel still needs a 1-bit field.
  function automatic int unsigned calc_ch_bits(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, active/shadow divisors, pending flag, toggle and tick.
module divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int unsigned      WIDTH           = DefaultWidth,
  parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(1)
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic             halt,
  input  logic             sync,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_divisor,
  output logic             output_clock,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH:0]   count_next;
  logic             transfer;

  // One extra bit so a divisor of 2^WIDTH-1 cannot wrap the comparison.
  assign count_next = {1'b0, count_q} + (WIDTH + 1)'(1);

  always_comb begin
    count_d   = count_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    active_d  = active_q;
    shadow_d  = load_en ? load_divisor : shadow_q;
    pending_d = pending_q | load_en;
    transfer  = 1'b0;

    if (sync) begin
      count_d  = '0;
      clk_d    = 1'b0;
      transfer = pending_q;
    end else if (halt) begin
      // Hold everything; loads above still reach the shadow.
    end else if (active_q == WIDTH'(DIVISOR_DISABLED)) begin
      count_d  = '0;
      clk_d    = 1'b0;
      transfer = pending_q;
    end else if (count_next >= {1'b0, active_q}) begin
      count_d  = '0;
      clk_d    = ~clk_q;
      tick_d   = 1'b1;
      transfer = pending_q;
    end else begin
      count_d = count_next[WIDTH-1:0];
    end

    // Transfer uses the shadow as it was before this cycle's load.
    if (transfer) begin
      active_d  = shadow_q;
      pending_d = load_en;
    end
  end

  always_ff @(posedge input_clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= DEFAULT_DIVISOR;
      shadow_q  <= DEFAULT_DIVISOR;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign output_clock = clk_q;
  assign tick         = tick_q;
  assign pending      = pending_q;

endmodule

// File: rtl/multi_clock_divider.sv
// CHANNELS independent programmable clock dividers sharing one input clock.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int unsigned      CHANNELS        = DefaultChannels,
  parameter int unsigned      WIDTH           = DefaultWidth,
  parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(1),
  parameter int unsigned      CH_BITS         = calc_ch_bits(CHANNELS)
) (
  input  logic                input_clock,
  input  logic                reset,
  input  logic                halt,
  input  logic                sync,
  input  logic                load_valid,
  input  logic [CH_BITS-1:0]  load_channel,
  input  logic [WIDTH-1:0]    load_divisor,
  output logic [CHANNELS-1:0] output_clock,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] load_en;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    // Out-of-range selects match no channel and are dropped.
    assign load_en[i] = load_valid && (load_channel == CH_BITS'(i));

    divider_channel #(
      .WIDTH           (WIDTH),
      .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) u_channel (
      .input_clock  (input_clock),
      .reset        (reset),
      .halt         (halt),
      .sync         (sync),
      .load_en      (load_en[i]),
      .load_divisor (load_divisor),
      .output_clock (output_clock[i]),
      .tick         (tick[i]),
      .pending      (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomized scoreboard bench for multi_clock_divider against a cycle-level behavioural model.
module tb_multi_clock_divider;

  localparam int unsigned Ch = 4;
  localparam int unsigned W  = 4;

  logic         input_clock = 1'b0;
  logic         reset = 1'b1;
  logic         halt = 1'b0;
  logic         sync = 1'b0;
  logic         load_valid = 1'b0;
  logic [1:0]   load_channel = '0;
  logic [W-1:0] load_divisor = '0;
  logic [Ch-1:0] output_clock, tick, pending;
  logic [2:0]    oc3, tick3, pend3;

  multi_clock_divider #(
    .CHANNELS        (Ch),
    .WIDTH           (W),
    .DEFAULT_DIVISOR (W'(1))
  ) u_dut (
    .input_clock  (input_clock),
    .reset        (reset),
    .halt         (halt),
    .sync         (sync),
    .load_valid   (load_valid),
    .load_channel (load_channel),
    .load_divisor (load_divisor),
    .output_clock (output_clock),
    .tick         (tick),
    .pending      (pending)
  );

  // Three-channel copy: load_channel 3 is out of range here, so channels 0..2 must still
  // match the four-channel model exactly.
  multi_clock_divider #(
    .CHANNELS        (3),
    .WIDTH           (W),
    .DEFAULT_DIVISOR (W'(1))
  ) u_dut3 (
    .input_clock  (input_clock),
    .reset        (reset),
    .halt         (halt),
    .sync         (sync),
    .load_valid   (load_valid),
    .load_channel (load_channel),
    .load_divisor (load_divisor),
    .output_clock (oc3),
    .tick         (tick3),
    .pending      (pend3)
  );

  always #5 input_clock = ~input_clock;

  typedef struct packed {
    logic [Ch-1:0] clk;
    logic [Ch-1:0] tck;
    logic [Ch-1:0] pnd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: elapsed count, active divisor, and a pending divisor (-1 = none).
  int m_cnt[Ch];
  int m_act[Ch];
  int m_pend[Ch];
  bit m_clk[Ch];
  bit m_tick[Ch];

  function automatic void model_step(bit r, bit h, bit s, bit lv, int ch, int div);
    for (int c = 0; c < Ch; c++) begin
      int  old_pend;
      bit  boundary;
      old_pend = m_pend[c];
      boundary = 1'b0;
      m_tick[c] = 1'b0;
      if (r) begin
        m_cnt[c] = 0; m_clk[c] = 1'b0; m_act[c] = 1; m_pend[c] = -1;
      end else begin
        if (s) begin
          m_cnt[c] = 0; m_clk[c] = 1'b0; boundary = 1'b1;
        end else if (h) begin
          boundary = 1'b0;
        end else if (m_act[c] == 0) begin
          m_cnt[c] = 0; m_clk[c] = 1'b0; boundary = 1'b1;
        end else if (m_cnt[c] + 1 >= m_act[c]) begin
          m_cnt[c] = 0; m_clk[c] = !m_clk[c]; m_tick[c] = 1'b1; boundary = 1'b1;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        if (boundary && old_pend >= 0) begin
          m_act[c] = old_pend;
          m_pend[c] = -1;
        end
        if (lv && ch == c) m_pend[c] = div;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int c = 0; c < Ch; c++) begin
      e.clk[c] = m_clk[c];
      e.tck[c] = m_tick[c];
      e.pnd[c] = (m_pend[c] >= 0);
    end
    return e;
  endfunction

  task automatic drive(input bit r, input bit h, input bit s, input bit lv, input int ch,
                       input int div);
    @(negedge input_clock);
    reset = r; halt = h; sync = s; load_valid = lv;
    load_channel = 2'(ch);
    load_divisor = W'(div);
    if (r) begin
      #1;
      checks++;
      if ({output_clock, tick, pending, oc3, tick3, pend3} != '0) begin
        errors++;
        $display("FAIL async_reset: got clk=%b tick=%b pend=%b (3ch %b %b %b) expected all 0",
                 output_clock, tick, pending, oc3, tick3, pend3);
      end
    end
    model_step(r, h, s, lv, ch, div);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic load(input int ch, input int div);
    drive(1'b0, 1'b0, 1'b0, 1'b1, ch, div);
  endtask

  // Monitor: every clock edge the DUT presents a new output state.
  initial begin
    exp_t e;
    forever begin
      @(posedge input_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (output_clock != e.clk || tick != e.tck || pending != e.pnd) begin
          errors++;
          $display("FAIL outputs @%0t: got clk=%b tick=%b pend=%b expected clk=%b tick=%b pend=%b",
                   $time, output_clock, tick, pending, e.clk, e.tck, e.pnd);
        end
        checks++;
        if (oc3 != e.clk[2:0] || tick3 != e.tck[2:0] || pend3 != e.pnd[2:0]) begin
          errors++;
          $display("FAIL outputs_3ch @%0t: got clk=%b tick=%b pend=%b expected clk=%b tick=%b pend=%b",
                   $time, oc3, tick3, pend3, e.clk[2:0], e.tck[2:0], e.pnd[2:0]);
        end
      end
    end
  end

  initial begin
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Default divisor 1 on every channel.
    idle(6);
    // Reprogram two channels while running.
    load(0, 5); load(1, 3); idle(14);
    // Disable, then re-enable, channel 2.
    load(2, 4); idle(10); load(2, 0); idle(10); load(2, 2); idle(8);
    // Halt mid-period with a load accepted during the halt.
    idle(2);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, (i == 3), 0, 8);
    idle(20);
    // Phase-align with sync while mid-count.
    load(0, 5); load(1, 3); idle(7);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(10);
    // Reset with loads pending, then the largest divisor and an out-of-range select.
    load(0, 7); load(1, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(5);
    load(3, 15); load(0, 15); idle(40);
    load(3, 2); idle(6);

    for (int i = 0; i < 3000; i++) begin
      bit r, h, s, lv;
      int div;
      r  = ($urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 99) < 10);
      s  = ($urandom_range(0, 99) < 3);
      lv = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 9) == 0) div = 0;
      else if ($urandom_range(0, 7) == 0) div = $urandom_range(1, 15);
      else div = $urandom_range(1, 4);
      drive(r, h, s, lv, $urandom_range(0, 3), div);
    end

    idle(1);
    repeat (2) @(posedge input_clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
